// File: rtl/wb_queue.sv
// Register-file writeback queue: two push ports, one in-order drain per cycle, pending-write lookup for two decode sources.
// Latency: an entry pushed into an empty queue drives wb_* in the cycle after its accepting edge.
// Backpressure: in_ready drops once fewer than two slots remain; pushes while not ready are dropped. Optional forwarding: WBQ_FWD_EN.
module wb_queue #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push0,
    input  logic [ADDR_WIDTH-1:0]   dest0,
    input  logic [WORD_WIDTH-1:0]   res0,
    input  logic                    push1,
    input  logic [ADDR_WIDTH-1:0]   dest1,
    input  logic [WORD_WIDTH-1:0]   res1,
    output logic                    in_ready,
    input  logic                    hold,
    output logic                    wb_en,
    output logic [ADDR_WIDTH-1:0]   wb_dest,
    output logic [WORD_WIDTH-1:0]   wb_res,
    input  logic [ADDR_WIDTH-1:0]   src1,
    input  logic [ADDR_WIDTH-1:0]   src2,
    output logic                    hit1,
    output logic                    hit2,
    output logic [WORD_WIDTH-1:0]   fwd1,
    output logic [WORD_WIDTH-1:0]   fwd2,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] dest_q [DEPTH];
    logic [WORD_WIDTH-1:0] res_q  [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, wr1_idx;
    logic [CW-1:0]         count_q, count_d;
    logic                  acc0, acc1, pop;

    always_comb begin
        in_ready = (count_q <= CW'(DEPTH - 2));
        acc0     = push0 & in_ready;
        acc1     = push1 & in_ready;
        pop      = (count_q != '0) && !hold;
        // Port 0 is the older of a same-cycle pair, so port 1 lands behind it.
        wr1_idx  = tail_q + PW'(acc0);
        head_d   = head_q + PW'(pop);
        tail_d   = tail_q + PW'(acc0) + PW'(acc1);
        count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (acc0) begin
                dest_q[tail_q] <= dest0;
                res_q[tail_q]  <= res0;
            end
            if (acc1) begin
                dest_q[wr1_idx] <= dest1;
                res_q[wr1_idx]  <= res1;
            end
        end
    end

    assign wb_en   = pop;
    assign wb_dest = dest_q[head_q];
    assign wb_res  = res_q[head_q];
    assign count   = count_q;

    logic [PW-1:0] hidx;
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        hidx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hidx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (dest_q[hidx] == src1) hit1 = 1'b1;
                if (dest_q[hidx] == src2) hit2 = 1'b1;
            end
        end
    end

`ifdef WBQ_FWD_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    logic [PW-1:0] fidx;
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        fidx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (dest_q[fidx] == src1) fwd1 = res_q[fidx];
                if (dest_q[fidx] == src2) fwd2 = res_q[fidx];
            end
        end
    end
`else
    assign fwd1 = '0;
    assign fwd2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_queue;
    localparam int WW = 32;
    localparam int AW = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          push0 = 1'b0, push1 = 1'b0, hold = 1'b0;
    logic [AW-1:0] dest0 = '0, dest1 = '0, src1 = '0, src2 = '0;
    logic [WW-1:0] res0 = '0, res1 = '0;
    logic          in_ready, wb_en, hit1, hit2;
    logic [AW-1:0] wb_dest;
    logic [WW-1:0] wb_res, fwd1, fwd2;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] d;
        logic [WW-1:0] r;
    } ent_t;
    ent_t mq[$];

    wb_queue #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .push0(push0), .dest0(dest0), .res0(res0),
        .push1(push1), .dest1(dest1), .res1(res1),
        .in_ready(in_ready), .hold(hold),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_res(wb_res),
        .src1(src1), .src2(src2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and apply the same edge to the reference queue.
    task automatic step();
        bit do_pop, rdy;
        do_pop = (mq.size() != 0) && !hold;
        rdy    = (mq.size() <= D - 2);
        @(posedge clk);
        if (do_pop) mq.delete(0);
        if (push0 && rdy) mq.push_back('{d: dest0, r: res0});
        if (push1 && rdy) mq.push_back('{d: dest1, r: res1});
        #1;
    endtask

    function automatic void mlook(input logic [AW-1:0] s, output bit h, output logic [WW-1:0] f);
        h = 1'b0;
        f = '0;
        foreach (mq[i]) if (mq[i].d == s) begin h = 1'b1; f = mq[i].r; end
`ifndef WBQ_FWD_EN
        f = '0;
`endif
    endfunction

    task automatic set_push(input bit p0, input logic [AW-1:0] d0, input logic [WW-1:0] r0,
                            input bit p1, input logic [AW-1:0] d1, input logic [WW-1:0] r1);
        push0 = p0; dest0 = d0; res0 = r0;
        push1 = p1; dest1 = d1; res1 = r1;
    endtask

    task automatic test_reset();
        // power-on state
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wb_en !== 1'b0 || count !== '0 || in_ready !== 1'b1 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
            errors++; $display("FAIL por_state: wb_en=%b count=%0d in_ready=%b hit=%b%b expected 0 0 1 00", wb_en, count, in_ready, hit1, hit2); end
        checks++; if (wb_dest !== '0 || wb_res !== '0 || fwd1 !== '0 || fwd2 !== '0) begin
            errors++; $display("FAIL por_data: wb_dest=%0h wb_res=%0h fwd=%0h/%0h expected all 0", wb_dest, wb_res, fwd1, fwd2); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // build count = 3 while draining
        hold = 1'b1; set_push(1, 4'd1, 32'h1, 1, 4'd2, 32'h2); step();
        hold = 1'b0; set_push(1, 4'd3, 32'h3, 1, 4'd4, 32'h4); step();
        set_push(0, 0, 0, 0, 0, 0); src1 = 4'd3; #1;
        checks++; if (count !== CW'(3) || wb_en !== 1'b1 || hit1 !== 1'b1) begin
            errors++; $display("FAIL middrain_setup: count=%0d wb_en=%b hit1=%b expected 3 1 1", count, wb_en, hit1); end
        rst_n = 1'b0; #1;
        mq.delete();
        checks++; if (wb_en !== 1'b0 || count !== '0 || hit1 !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL middrain_reset: wb_en=%b count=%0d hit1=%b in_ready=%b expected 0 0 0 1", wb_en, count, hit1, in_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        set_push(1, 4'd5, 32'hAA, 0, 0, 0); step();
        set_push(0, 0, 0, 0, 0, 0); #1;
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_res !== 32'hAA) begin
            errors++; $display("FAIL post_reset_push: wb_en=%b dest=%0d res=%0h expected 1 5 aa", wb_en, wb_dest, wb_res); end
        step();
    endtask

    task automatic test_dual_push();
        logic [AW-1:0] ed [2] = '{4'd2, 4'd3};
        logic [WW-1:0] er [2] = '{32'h11, 32'h22};
        set_push(1, 4'd2, 32'h11, 1, 4'd3, 32'h22); step();
        set_push(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (count !== CW'(2 - i) || wb_en !== 1'b1 || wb_dest !== ed[i] || wb_res !== er[i]) begin
                errors++; $display("FAIL dual_push[%0d]: count=%0d en=%b dest=%0d res=%0h expected %0d 1 %0d %0h",
                                   i, count, wb_en, wb_dest, wb_res, 2 - i, ed[i], er[i]); end
            step();
        end
        checks++; if (count !== '0 || wb_en !== 1'b0) begin
            errors++; $display("FAIL dual_push_empty: count=%0d wb_en=%b expected 0 0", count, wb_en); end
    endtask

    task automatic test_backpressure();
        hold = 1'b1;
        set_push(1, 4'd8, 32'h80, 1, 4'd9, 32'h90); step();
        set_push(1, 4'd10, 32'hA0, 1, 4'd11, 32'hB0); step();
        set_push(0, 0, 0, 0, 0, 0); #1;
        checks++; if (count !== CW'(4) || in_ready !== 1'b0 || wb_en !== 1'b0) begin
            errors++; $display("FAIL bp_full: count=%0d in_ready=%b wb_en=%b expected 4 0 0", count, in_ready, wb_en); end
        set_push(1, 4'd7, 32'h77, 0, 0, 0); step();
        set_push(0, 0, 0, 0, 0, 0); src1 = 4'd7; #1;
        checks++; if (count !== CW'(4) || hit1 !== 1'b0) begin
            errors++; $display("FAIL bp_drop: count=%0d hit1=%b expected 4 0", count, hit1); end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (wb_en !== 1'b1 || wb_dest !== AW'(8 + i) || wb_res !== WW'(32'h80 + 16 * i)) begin
                errors++; $display("FAIL bp_drain[%0d]: en=%b dest=%0d res=%0h expected 1 %0d %0h",
                                   i, wb_en, wb_dest, wb_res, 8 + i, 32'h80 + 16 * i); end
            checks++; if (in_ready !== (4 - i <= 2)) begin
                errors++; $display("FAIL bp_ready[%0d]: in_ready=%b expected %0b", i, in_ready, (4 - i <= 2)); end
            step();
        end
        checks++; if (count !== '0 || wb_en !== 1'b0) begin
            errors++; $display("FAIL bp_empty: count=%0d wb_en=%b expected 0 0", count, wb_en); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] d;
        logic [WW-1:0] r;
        for (int i = 0; i < 10; i++) begin
            d = AW'($urandom); r = $urandom;
            set_push(1, d, r, 0, 0, 0); step();
            checks++; if (count !== CW'(1) || wb_en !== 1'b1 || wb_dest !== d || wb_res !== r) begin
                errors++; $display("FAIL wrap[%0d]: count=%0d en=%b dest=%0d res=%0h expected 1 1 %0d %0h",
                                   i, count, wb_en, wb_dest, wb_res, d, r); end
        end
        set_push(0, 0, 0, 0, 0, 0); step();
    endtask

    task automatic test_lookup_priority();
        logic [WW-1:0] exp_f;
`ifdef WBQ_FWD_EN
        exp_f = 32'h20;
`else
        exp_f = 32'h0;
`endif
        hold = 1'b1;
        set_push(1, 4'd4, 32'h10, 1, 4'd4, 32'h20); step();
        set_push(0, 0, 0, 0, 0, 0); src1 = 4'd4; src2 = 4'd9; #1;
        checks++; if (hit1 !== 1'b1 || fwd1 !== exp_f || hit2 !== 1'b0 || fwd2 !== '0) begin
            errors++; $display("FAIL lookup_prio: hit1=%b fwd1=%0h hit2=%b fwd2=%0h expected 1 %0h 0 0", hit1, fwd1, hit2, fwd2, exp_f); end
        hold = 1'b0; step(); step();
    endtask

    task automatic test_simul_push_pop();
        hold = 1'b1;
        set_push(1, 4'd12, 32'hC0, 1, 4'd13, 32'hD0); step();
        hold = 1'b0;
        set_push(1, 4'd14, 32'hE0, 1, 4'd15, 32'hF0); #1;
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd12 || in_ready !== 1'b1) begin
            errors++; $display("FAIL simul_head: en=%b dest=%0d in_ready=%b expected 1 12 1", wb_en, wb_dest, in_ready); end
        step();
        set_push(0, 0, 0, 0, 0, 0); #1;
        checks++; if (count !== CW'(3) || wb_dest !== 4'd13) begin
            errors++; $display("FAIL simul_count: count=%0d dest=%0d expected 3 13", count, wb_dest); end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_random();
        bit            eh1, eh2;
        logic [WW-1:0] ef1, ef2;
        for (int c = 0; c < 400; c++) begin
            set_push($urandom_range(0, 1), AW'($urandom_range(0, 5)), $urandom,
                     $urandom_range(0, 1), AW'($urandom_range(0, 5)), $urandom);
            hold = ($urandom_range(0, 3) == 0);
            src1 = AW'($urandom_range(0, 6));
            src2 = AW'($urandom_range(0, 6));
            #1;
            mlook(src1, eh1, ef1);
            mlook(src2, eh2, ef2);
            checks++; if (count !== CW'(mq.size()) || in_ready !== (mq.size() <= D - 2)
                          || wb_en !== ((mq.size() != 0) && !hold)) begin
                errors++; $display("FAIL rnd_ctrl[%0d]: count=%0d in_ready=%b wb_en=%b expected size %0d hold %b",
                                   c, count, in_ready, wb_en, mq.size(), hold); end
            if (mq.size() != 0) begin
                checks++; if (wb_dest !== mq[0].d || wb_res !== mq[0].r) begin
                    errors++; $display("FAIL rnd_head[%0d]: dest=%0d res=%0h expected %0d %0h",
                                       c, wb_dest, wb_res, mq[0].d, mq[0].r); end
            end
            checks++; if (hit1 !== eh1 || hit2 !== eh2 || fwd1 !== ef1 || fwd2 !== ef2) begin
                errors++; $display("FAIL rnd_lookup[%0d]: hit=%b%b fwd=%0h/%0h expected %b%b %0h/%0h",
                                   c, hit1, hit2, fwd1, fwd2, eh1, eh2, ef1, ef2); end
            step();
        end
        set_push(0, 0, 0, 0, 0, 0); hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dual_push();
        test_backpressure();
        test_wrap();
        test_lookup_priority();
        test_simul_push_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
